// File: rtl/compl_mult_pipe.sv
// Three-stage pipelined complex multiplier, optional conjugate of b per sample.
// Define CMULT_SAT_EN to saturate the output; default build wraps.
module compl_mult_pipe #(
  parameter int WA    = 16,
  parameter int WB    = 16,
  parameter int WO    = 16,
  parameter int SHIFT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*WA-1:0] a,
  input  logic [2*WB-1:0] b,
  input  logic            conj,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*WO-1:0] o
);

  localparam int WP = WA + WB;
  localparam int WR = WP + 1;

  localparam logic signed [WR-1:0] RND =
    {{(WR-1){1'b0}}, 1'b1} << (SHIFT-1);

`ifdef CMULT_SAT_EN
  localparam logic signed [WR-1:0] MAXV =
    {{(WR-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [WR-1:0] MINV =
    {{(WR-WO+1){1'b1}}, {(WO-1){1'b0}}};
`endif

  // stage 1
  logic [2*WA-1:0] a_q;
  logic [2*WB-1:0] b_q;
  logic            cj1_q, v1_q;
  // stage 2
  logic signed [WP-1:0] pii_q, pqq_q, pqi_q, piq_q;
  logic signed [WP-1:0] pii_d, pqq_d, pqi_d, piq_d;
  logic                 cj2_q, v2_q;
  // stage 3
  logic [2*WO-1:0] o_q, o_d;
  logic            v3_q;

  logic signed [WP-1:0] ai_x, aq_x, bi_x, bq_x;
  logic signed [WR-1:0] ii_x, qq_x, qi_x, iq_x;
  logic signed [WR-1:0] re_x, im_x, re_r, im_r;
  logic                 stall;

  assign stall     = v3_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v3_q;
  assign o         = o_q;

  // Limit a rounded WR-bit value to WO bits.
  function automatic logic [WO-1:0] lim(
    input logic signed [WR-1:0] r
  );
`ifdef CMULT_SAT_EN
    if (r > MAXV)
      lim = WO'(MAXV);
    else if (r < MINV)
      lim = WO'(MINV);
    else
      lim = WO'(r);
`else
    lim = WO'(r);
`endif
  endfunction

  // Sign-extend components and form the four full-precision products.
  always_comb begin
    ai_x  = {{WB{a_q[2*WA-1]}}, a_q[2*WA-1:WA]};
    aq_x  = {{WB{a_q[WA-1]}}, a_q[WA-1:0]};
    bi_x  = {{WA{b_q[2*WB-1]}}, b_q[2*WB-1:WB]};
    bq_x  = {{WA{b_q[WB-1]}}, b_q[WB-1:0]};
    pii_d = ai_x * bi_x;
    pqq_d = aq_x * bq_x;
    pqi_d = aq_x * bi_x;
    piq_d = ai_x * bq_x;
  end

  // Combine products, round half-up, then limit to the output width.
  always_comb begin
    ii_x = {pii_q[WP-1], pii_q};
    qq_x = {pqq_q[WP-1], pqq_q};
    qi_x = {pqi_q[WP-1], pqi_q};
    iq_x = {piq_q[WP-1], piq_q};
    if (cj2_q) begin
      re_x = ii_x + qq_x;
      im_x = qi_x - iq_x;
    end else begin
      re_x = ii_x - qq_x;
      im_x = qi_x + iq_x;
    end
    re_r = (re_x + RND) >>> SHIFT;
    im_r = (im_x + RND) >>> SHIFT;
    o_d  = {lim(re_r), lim(im_r)};
  end

  // Pipeline registers; the whole pipe freezes while output is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      cj1_q <= 1'b0;
      v1_q  <= 1'b0;
      pii_q <= '0;
      pqq_q <= '0;
      pqi_q <= '0;
      piq_q <= '0;
      cj2_q <= 1'b0;
      v2_q  <= 1'b0;
      o_q   <= '0;
      v3_q  <= 1'b0;
    end else if (!stall) begin
      a_q   <= a;
      b_q   <= b;
      cj1_q <= conj;
      v1_q  <= in_valid;
      pii_q <= pii_d;
      pqq_q <= pqq_d;
      pqi_q <= pqi_d;
      piq_q <= piq_d;
      cj2_q <= cj1_q;
      v2_q  <= v1_q;
      o_q   <= o_d;
      v3_q  <= v2_q;
    end
  end

endmodule

// File: tb/tb_compl_mult_pipe.sv
// Scoreboard bench for compl_mult_pipe at 16/16/16, SHIFT=15.
// Reference model works on plain integers; checks run in a monitor.
module tb_compl_mult_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        conj;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] o;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int stalls = 0;
  bit rand_bp = 0;

  logic [31:0] exp_q[$];
  int          cyc_q[$];
  int          stl_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_o = '0;

  compl_mult_pipe #(
    .WA(16), .WB(16), .WO(16), .SHIFT(15)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .conj     (conj),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .o        (o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] cx(int re, int im);
    logic [31:0] r, i;
    r = re;
    i = im;
    return {r[15:0], i[15:0]};
  endfunction

  function automatic logic [15:0] narrow(longint x);
`ifdef CMULT_SAT_EN
    if (x > 32767) x = 32767;
    if (x < -32768) x = -32768;
`endif
    return x[15:0];
  endfunction

  // Complex product, optional conjugate, round half-up, narrow.
  function automatic logic [31:0] model(
    logic [31:0] av, logic [31:0] bv, logic cj
  );
    longint ai, aq, bi, bq, re, im;
    ai = longint'($signed(av[31:16]));
    aq = longint'($signed(av[15:0]));
    bi = longint'($signed(bv[31:16]));
    bq = longint'($signed(bv[15:0]));
    if (cj) bq = -bq;
    re = ai * bi - aq * bq;
    im = aq * bi + ai * bq;
    re = (re + 16384) >>> 15;
    im = (im + 16384) >>> 15;
    return {narrow(re), narrow(im)};
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               nm, act, req, cyc);
    end
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, conj));
        cyc_q.push_back(cyc);
        stl_q.push_back(stalls);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          int t0, s0;
          t0 = cyc_q.pop_front();
          s0 = stl_q.pop_front();
          check("result", o, exp_q.pop_front());
          if (s0 == stalls)
            check("latency", 32'(cyc - t0), 32'd3);
        end
      end
      if (out_valid && !out_ready) begin
        check("in_ready_stall", 32'(in_ready), 32'd0);
        if (prev_stall) check("o_hold", o, prev_o);
        stalls++;
      end
      prev_stall = out_valid && !out_ready;
      prev_o     = o;
    end
  end

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = ($urandom % 4) != 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] av, logic [31:0] bv, logic cj);
    int n;
    a        = av;
    b        = bv;
    conj     = cj;
    in_valid = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 32'd1, 32'd0);
    step();
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom % 4)
      0:       return cx(-32768, -32768);
      1:       return cx(32767, -32768);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    conj      = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_o", o, 32'd0);
    reset = 1'b0;
    step();

    // plain and conjugate multiply, back-to-back mode change
    send(cx(16384, 16384), cx(16384, -16384), 1'b0);
    idle(5);
    send(cx(16384, 16384), cx(16384, 16384), 1'b1);
    send(cx(16384, 16384), cx(16384, 16384), 1'b0);
    idle(5);
    // rounding around half
    send(cx(1, 0), cx(16384, 0), 1'b0);
    send(cx(-1, 0), cx(16384, 0), 1'b0);
    // overflow corner
    send(cx(-32768, -32768), cx(-32768, 32768), 1'b0);
    drain();

    // backpressure mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(cx(1000 * i + 7, -300 * i), cx(-2000 + i, 5000 * i),
               i[0]);
        in_valid = 1'b0;
      end
      begin
        repeat (5) step();
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
      end
    join
    drain();

    // reset with three samples in flight
    send(cx(100, 200), cx(300, 400), 1'b0);
    send(cx(500, 600), cx(700, 800), 1'b1);
    send(cx(900, 1000), cx(1100, 1200), 1'b0);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_o", o, 32'd0);
    exp_q.delete();
    cyc_q.delete();
    stl_q.delete();
    repeat (2) step();
    reset = 1'b0;
    idle(8);
    send(cx(-12345, 2222), cx(3333, -4444), 1'b1);
    drain();

    // random traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 3 == 0) idle(1);
      send(rnd_op(), rnd_op(), 1'($urandom % 2));
    end
    in_valid = 1'b0;
    rand_bp  = 1'b0;
    step();
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
